// File: rtl/data_timer.sv
// Memory-mapped 64-bit machine timer (MTIME/MTIMECMP) with a sticky pending flag and an interrupt output.
// Optional macro TIMER_PRESCALER_EN adds a 16-bit tick prescaler at index 6. Response latency is 1 cycle and there is no stall.
module data_timer #(
  parameter logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_byteen,
  output logic        data_gnt,
  output logic [31:0] data_rdata,
  output logic        data_valid,
  output logic        intr
);

  localparam logic [2:0] IDX_CTRL  = 3'd0;
  localparam logic [2:0] IDX_MLO   = 3'd1;
  localparam logic [2:0] IDX_MHI   = 3'd2;
  localparam logic [2:0] IDX_CLO   = 3'd3;
  localparam logic [2:0] IDX_CHI   = 3'd4;
  localparam logic [2:0] IDX_STAT  = 3'd5;
  localparam logic [2:0] IDX_PRESC = 3'd6;

  function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  be);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

  logic        r_en;
  logic        r_ie;
  logic        r_pend;
  logic [63:0] r_mtime;
  logic [63:0] r_cmp;
  logic        r_valid;
  logic [31:0] r_rdata;

  logic [2:0]  w_idx;
  logic        w_wr;
  logic        w_rd;
  logic        w_tick;
  logic        w_cmp;
  logic        w_clr;
  logic [31:0] w_ps_rd;
  logic [31:0] w_rd_mux;
  logic [63:0] w_mtime_nxt;
  logic [63:0] w_cmp_nxt;
  logic        w_unused;

  assign w_idx    = data_addr[4:2];
  assign w_wr     = data_req & data_wr;
  assign w_rd     = data_req & ~data_wr;
  assign w_unused = ^{data_addr[31:5], data_addr[1:0]};
  assign data_gnt = data_req;

`ifdef TIMER_PRESCALER_EN
  logic [15:0] r_prescale;
  logic [15:0] r_ps_cnt;
  logic        w_we_ps;

  assign w_we_ps = w_wr && (w_idx == IDX_PRESC);
  assign w_tick  = r_en && (r_ps_cnt == r_prescale);
  assign w_ps_rd = {16'h0000, r_prescale};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prescale <= 16'h0000;
      r_ps_cnt   <= 16'h0000;
    end else if (w_we_ps) begin
      if (data_byteen[0]) r_prescale[7:0]  <= data_wdata[7:0];
      if (data_byteen[1]) r_prescale[15:8] <= data_wdata[15:8];
      r_ps_cnt <= 16'h0000;
    end else if (r_en) begin
      r_ps_cnt <= (r_ps_cnt == r_prescale) ? 16'h0000 : r_ps_cnt + 16'd1;
    end
  end
`else
  assign w_tick  = r_en;
  assign w_ps_rd = 32'h0000_0000;
`endif

  // A software write to either MTIME half replaces the increment for that cycle.
  always_comb begin
    w_mtime_nxt = r_mtime;
    if (w_wr && w_idx == IDX_MLO)
      w_mtime_nxt[31:0] = f_merge(r_mtime[31:0], data_wdata, data_byteen);
    else if (w_wr && w_idx == IDX_MHI)
      w_mtime_nxt[63:32] = f_merge(r_mtime[63:32], data_wdata, data_byteen);
    else if (w_tick)
      w_mtime_nxt = r_mtime + 64'd1;
  end

  always_comb begin
    w_cmp_nxt = r_cmp;
    if (w_wr && w_idx == IDX_CLO)
      w_cmp_nxt[31:0] = f_merge(r_cmp[31:0], data_wdata, data_byteen);
    else if (w_wr && w_idx == IDX_CHI)
      w_cmp_nxt[63:32] = f_merge(r_cmp[63:32], data_wdata, data_byteen);
  end

  always_comb begin
    w_rd_mux = 32'h0000_0000;
    case (w_idx)
      IDX_CTRL:  w_rd_mux = {30'd0, r_ie, r_en};
      IDX_MLO:   w_rd_mux = r_mtime[31:0];
      IDX_MHI:   w_rd_mux = r_mtime[63:32];
      IDX_CLO:   w_rd_mux = r_cmp[31:0];
      IDX_CHI:   w_rd_mux = r_cmp[63:32];
      IDX_STAT:  w_rd_mux = {31'd0, r_pend};
      IDX_PRESC: w_rd_mux = w_ps_rd;
      default:   w_rd_mux = 32'h0000_0000;
    endcase
  end

  assign w_cmp = (r_mtime >= r_cmp);
  assign w_clr = w_wr && (w_idx == IDX_STAT) && data_byteen[0] && data_wdata[0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_en    <= 1'b0;
      r_ie    <= 1'b0;
      r_pend  <= 1'b0;
      r_mtime <= 64'd0;
      r_cmp   <= CMP_RST;
    end else begin
      r_mtime <= w_mtime_nxt;
      r_cmp   <= w_cmp_nxt;
      if (w_wr && w_idx == IDX_CTRL && data_byteen[0]) begin
        r_en <= data_wdata[0];
        r_ie <= data_wdata[1];
      end
      // Set beats a coincident write-1-clear.
      if (w_cmp && r_en)
        r_pend <= 1'b1;
      else if (w_clr)
        r_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_rdata <= 32'h0000_0000;
    end else begin
      r_valid <= data_req;
      r_rdata <= w_rd ? w_rd_mux : 32'h0000_0000;
    end
  end

  assign data_valid = r_valid;
  assign data_rdata = r_rdata;
  assign intr       = r_pend & r_ie;

endmodule

// File: tb/tb_data_timer.sv
// Directed self-checking bench for data_timer; expected values are hand-computed constants.
module tb_data_timer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        data_req = 1'b0;
  logic        data_wr = 1'b0;
  logic [31:0] data_addr = 32'h0;
  logic [31:0] data_wdata = 32'h0;
  logic [3:0]  data_byteen = 4'h0;
  logic        data_gnt;
  logic [31:0] data_rdata;
  logic        data_valid;
  logic        intr;

  int n_chk = 0;
  int n_fail = 0;

`ifdef TIMER_PRESCALER_EN
  localparam int PS_DIV = 4;
  localparam logic [31:0] PS_RD = 32'd3;
`else
  localparam int PS_DIV = 1;
  localparam logic [31:0] PS_RD = 32'd0;
`endif

  data_timer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .data_req    (data_req),
    .data_wr     (data_wr),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_byteen (data_byteen),
    .data_gnt    (data_gnt),
    .data_rdata  (data_rdata),
    .data_valid  (data_valid),
    .intr        (intr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic access(input logic wr, input logic [2:0] idx, input logic [31:0] wd,
                        input logic [3:0] be, output logic [31:0] rd);
    @(negedge clk);
    data_req    = 1'b1;
    data_wr     = wr;
    data_addr   = {27'd0, idx, 2'b00};
    data_wdata  = wd;
    data_byteen = be;
    #1 chk("gnt", {31'd0, data_gnt}, 32'd1);
    @(posedge clk);
    #1;
    data_req = 1'b0;
    data_wr  = 1'b0;
    chk("valid", {31'd0, data_valid}, 32'd1);
    rd = data_rdata;
  endtask

  task automatic wr(input logic [2:0] idx, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] dummy;
    access(1'b1, idx, wd, be, dummy);
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] idx, input logic [31:0] exp);
    logic [31:0] v;
    access(1'b0, idx, 32'h0, 4'h0, v);
    chk(tag, v, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    chk("rst_valid", {31'd0, data_valid}, 32'd0);
    chk("rst_rdata", data_rdata, 32'd0);
    chk("rst_intr", {31'd0, intr}, 32'd0);

    // Request on the first edge after release
    @(negedge clk);
    reset_n   = 1'b1;
    data_req  = 1'b1;
    data_wr   = 1'b0;
    data_addr = 32'h0000_0000;
    #1 chk("first_gnt", {31'd0, data_gnt}, 32'd1);
    @(posedge clk);
    #1;
    data_req = 1'b0;
    chk("first_valid", {31'd0, data_valid}, 32'd1);
    chk("first_rdata", data_rdata, 32'd0);
    @(posedge clk);
    #1;
    chk("idle_valid", {31'd0, data_valid}, 32'd0);
    chk("idle_rdata", data_rdata, 32'd0);

    // Byte enables, no-op write, reserved slots
    wr(3'd3, 32'h1234_5678, 4'b0010);
    rd_chk("cmplo_byte", 3'd3, 32'hFFFF_56FF);
    wr(3'd4, 32'h0, 4'b0000);
    rd_chk("cmphi_be0", 3'd4, 32'hFFFF_FFFF);
    rd_chk("b2b_0", 3'd3, 32'hFFFF_56FF);
    rd_chk("b2b_1", 3'd4, 32'hFFFF_FFFF);
    rd_chk("b2b_2", 3'd0, 32'h0);
    @(posedge clk);
    #1 chk("after_b2b_valid", {31'd0, data_valid}, 32'd0);
    wr(3'd7, 32'hFFFF_FFFF, 4'hF);
    rd_chk("reserved", 3'd7, 32'h0);
    wr(3'd0, 32'hFFFF_FFFC, 4'hF);
    rd_chk("ctrl_unused", 3'd0, 32'h0);

    // Compare -> PEND -> intr timing
    wr(3'd3, 32'd10, 4'hF);
    wr(3'd4, 32'd0, 4'hF);
    rd_chk("no_pend_en0", 3'd5, 32'h0);
    wr(3'd0, 32'd3, 4'hF);
    repeat (10) @(posedge clk);
    #1 chk("intr_at_cmp", {31'd0, intr}, 32'd0);
    @(posedge clk);
    #1 chk("intr_after_cmp", {31'd0, intr}, 32'd1);
    rd_chk("pend_set", 3'd5, 32'd1);

    // Clear while compare true, then clear after raising MTIMECMP
    wr(3'd5, 32'd1, 4'hF);
    rd_chk("pend_set_wins", 3'd5, 32'd1);
    wr(3'd4, 32'd1, 4'hF);
    wr(3'd5, 32'd1, 4'hF);
    chk("intr_cleared", {31'd0, intr}, 32'd0);
    rd_chk("pend_cleared", 3'd5, 32'd0);

    // 64-bit wrap after exactly one tick
    wr(3'd0, 32'd0, 4'hF);
    wr(3'd1, 32'hFFFF_FFFF, 4'hF);
    wr(3'd2, 32'hFFFF_FFFF, 4'hF);
    wr(3'd0, 32'd1, 4'hF);
    wr(3'd0, 32'd0, 4'hF);
    rd_chk("wrap_lo", 3'd1, 32'h0);
    rd_chk("wrap_hi", 3'd2, 32'h0);
    wr(3'd5, 32'd1, 4'hF);

    // Write to MTIME_HI beats the increment; LO holds
    wr(3'd1, 32'hFFFF_FFFF, 4'hF);
    wr(3'd2, 32'h0, 4'hF);
    wr(3'd0, 32'd1, 4'hF);
    wr(3'd2, 32'd5, 4'hF);
    wr(3'd0, 32'd0, 4'hF);
    rd_chk("prio_lo", 3'd1, 32'h0);
    rd_chk("prio_hi", 3'd2, 32'd6);

    // Tick rate
    wr(3'd1, 32'h0, 4'hF);
    wr(3'd2, 32'h0, 4'hF);
    wr(3'd6, 32'd3, 4'hF);
    rd_chk("presc_rd", 3'd6, PS_RD);
    wr(3'd0, 32'd1, 4'hF);
    for (int i = 0; i < 9; i++) begin
      rd_chk($sformatf("tick_%0d", i), 3'd1, 32'(i / PS_DIV));
    end

    // Reset in the middle of a response
    wr(3'd0, 32'd0, 4'hF);
    wr(3'd6, 32'd0, 4'hF);
    wr(3'd3, 32'd0, 4'hF);
    wr(3'd4, 32'd0, 4'hF);
    wr(3'd0, 32'd3, 4'hF);
    @(posedge clk);
    #1 chk("pre_rst_intr", {31'd0, intr}, 32'd1);
    @(negedge clk);
    data_req  = 1'b1;
    data_wr   = 1'b0;
    data_addr = 32'h0000_0000;
    @(posedge clk);
    #1;
    data_req = 1'b0;
    reset_n  = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, data_valid}, 32'd0);
    chk("midrst_rdata", data_rdata, 32'd0);
    chk("midrst_intr", {31'd0, intr}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1 chk("post_rst_valid", {31'd0, data_valid}, 32'd0);
    rd_chk("rst_ctrl", 3'd0, 32'h0);
    rd_chk("rst_mlo", 3'd1, 32'h0);
    rd_chk("rst_mhi", 3'd2, 32'h0);
    rd_chk("rst_clo", 3'd3, 32'hFFFF_FFFF);
    rd_chk("rst_chi", 3'd4, 32'hFFFF_FFFF);
    rd_chk("rst_stat", 3'd5, 32'h0);
    rd_chk("rst_presc", 3'd6, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/data_timer.md
DATA_TIMER -- requirements
Module: data_timer

Interface
REQ-001 SHALL have parameter: CMP_RST  64'hFFFF_FFFF_FFFF_FFFF  reset value of MTIMECMP.
REQ-002 SHALL have port: clk  in  1  single clock; all state on rising edge.
REQ-003 SHALL have port: reset_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port: data_req  in  1  request from core data port.
REQ-005 SHALL have port: data_wr  in  1  1=write, 0=read; qualified by data_req.
REQ-006 SHALL have port: data_addr  in  32  byte address; only bits [4:2] decoded.
REQ-007 SHALL have port: data_wdata  in  32  write data.
REQ-008 SHALL have port: data_byteen  in  4  write byte enables.
REQ-009 SHALL have port: data_gnt  out  1  request accepted.
REQ-010 SHALL have port: data_rdata  out  32  read data, valid with data_valid.
REQ-011 SHALL have port: data_valid  out  1  response strobe.
REQ-012 SHALL have port: intr  out  1  timer interrupt to core.

Function
REQ-013 SHALL drive data_gnt = data_req combinationally, so one request can be accepted every cycle with no stall.
REQ-014 SHALL assert data_valid exactly one cycle after each grant, for one cycle, for both reads and writes; back-to-back grants give back-to-back valids.
REQ-015 SHALL sample read data in the grant cycle (pre-write, pre-increment values) and hold it on data_rdata with data_valid; data_rdata SHALL be 0 when data_valid=0.
REQ-016 SHALL use this register map (addr[4:2]): 0 CTRL (bit0 EN, bit1 IE), 1 MTIME_LO, 2 MTIME_HI, 3 MTIMECMP_LO, 4 MTIMECMP_HI, 5 STATUS (bit0 PEND, write-1-clear), 6 PRESCALE (see Configuration), 7 reserved.
REQ-017 SHALL read unused and reserved bits as 0, and SHALL ignore writes to them.
REQ-018 SHALL apply writes in the grant cycle, per byte lane according to data_byteen; byteen=0000 SHALL be a no-op that still responds.
REQ-019 SHALL increment the 64-bit MTIME by 1 on each tick while EN=1, wrapping from 2^64-1 to 0.
REQ-020 SHALL give a software write to either MTIME half priority over the increment in that cycle; the other half SHALL keep its value with no carry into it.
REQ-021 SHALL evaluate compare = (MTIME >= MTIMECMP), 64-bit unsigned, from registered values every cycle.
REQ-022 SHALL set PEND the cycle after compare is true while EN=1; PEND SHALL be sticky.
REQ-023 SHALL clear PEND on a write of 1 to STATUS bit0; if set and clear coincide, set SHALL win.
REQ-024 SHALL drive intr = PEND & IE, registered-free from the PEND and IE flops.
REQ-025 SHALL NOT set PEND on an MTIMECMP half-write when the new 64-bit value does not satisfy compare.

Reset
REQ-026 SHALL, on reset_n low, asynchronously set CTRL=0, MTIME=0, MTIMECMP=CMP_RST, PEND=0, PRESCALE=0 and the prescale counter to 0.
REQ-027 SHALL hold data_valid=0, data_rdata=0 and intr=0 during reset.
REQ-028 SHALL discard a response pending when reset asserts; no valid SHALL appear after reset releases.
REQ-029 SHALL accept requests on the first clock edge after reset_n deasserts.

Configuration
REQ-030 SHALL support macro TIMER_PRESCALER_EN.
REQ-031 SHALL, when TIMER_PRESCALER_EN is defined, implement PRESCALE[15:0] at index 6 and generate a tick once every PRESCALE+1 enabled cycles, restarting the prescale count on any PRESCALE write.
REQ-032 SHALL, when TIMER_PRESCALER_EN is undefined, tick every cycle while EN=1, read index 6 as 0, and ignore writes to it.

Verification
REQ-033 SHALL cover: reset, then read CTRL at 0x00 -> data_gnt in the same cycle; data_valid next cycle with data_rdata=0.
REQ-034 SHALL cover: write MTIMECMP_LO=10, MTIMECMP_HI=0, CTRL=3 -> PEND=1 and intr=1 when MTIME reaches 10, with intr rising the cycle after compare becomes true.
REQ-035 SHALL cover: write 1 to STATUS with compare still true -> PEND stays 1; set MTIMECMP_HI=1 and then write 1 to STATUS -> intr=0.
REQ-036 SHALL cover: MTIME_LO=FFFFFFFF, MTIME_HI=FFFFFFFF, EN=1 -> MTIME wraps to 0 after one tick, and a read returns 0 in both halves.
REQ-037 SHALL cover: write 0x12345678 to MTIMECMP_LO with byteen=0010 -> reads back 0xFFFF56FF (CMP_RST default); consecutive read requests in 3 cycles -> 3 consecutive valids.
REQ-038 SHALL cover, with TIMER_PRESCALER_EN: PRESCALE=3, EN=1 -> MTIME increments once every 4 cycles; assert reset mid-response -> data_valid=0 and all registers at reset values.
